init_operation_cont_ld: RTL and testbench
=========================================

# init_operation_cont_ld

Control core of the agricultural automation chain. It has three parts:
- an initialization sequencer (Init_FSM behaviour), which walks four actuator/sensor steps after a start command and then raises a ready flag;
- a level-control sequencer (Operation_FSM behaviour), which regulates a reservoir from three level sensors once the ready flag and the process-phase enable are high;
- a 4-bit loadable down-counter (ContLd behaviour), which the timing controller uses as its timebase.

All three run on one clock and one reset.

## Interface
Parameters: none (counter width fixed at 4).

Ports:
- Ck  in  1  system clock; all state updates on rising edge
- Clr  in  1  reset, synchronous, active-high; clears all three sub-blocks
- Start  in  1  initialization start request (level, sampled in IDLE only)
- I1..I4  in  1 each  initialization step confirmation sensors
- I5  in  1  reservoir high-level sensor
- I6  in  1  reservoir mid-level sensor
- I7  in  1  reservoir low-level sensor
- O6  in  1  process-phase enable from the process sequencer
- CE  in  1  counter enable
- Ld  in  1  counter synchronous load
- I  in  4  counter load value
- O1..O4  out  1 each  initialization actuator commands
- H1  out  1  initialization complete (ready)
- O7  out  1  level-sensor fault alarm
- O8  out  1  reservoir full indicator
- O9  out  1  fill pump command
- Q  out  4  counter value
- RC  out  1  terminal count

## Operation
Init sequencer:
- States: IDLE, W1, W2, W3, W4, DONE.
- Outputs are Moore. On is high in state Wn and in every later state, so O1..O4 are cumulative. H1=1 only in DONE.
- IDLE -> W1 when Start=1.
- Wn -> W(n+1) when In=1. W4 -> DONE when I4=1.
- Otherwise the sequencer holds its state.
- DONE is absorbing until Clr.
- Sensors are level-sampled each cycle. A sensor already high advances one state per cycle.

Level sequencer:
- Enabled only when en = H1 & O6. If en=0, the next state is OFF from any state.
- States and outputs:
  - OFF: all outputs 0.
  - FILL: O9=1.
  - FULL: O8=1.
  - FAULT: O7=1.
- Inconsistent sensors: incons = (I5 & ~I6) | (I6 & ~I7). With en=1, incons=1 forces FAULT from any state; this has priority over all other transitions.
- OFF -> FILL when en=1 and I5=0; OFF -> FULL when en=1 and I5=1.
- FILL -> FULL when I5=1.
- FULL -> FILL when I6=0. This gives hysteresis: the pump restarts below mid level, not below high level.
- FAULT -> OFF when incons=0.

Counter:
- Priority: Clr, then Ld, then CE.
- Clr: Q=0.
- Ld=1: Q=I, whatever CE is.
- CE=1 and Ld=0: Q=Q-1 modulo 16, so 0 wraps to 15.
- Otherwise Q holds.
- RC = CE & (Q==0), combinational from the registered Q.

## Timing
- Reset values: init state IDLE, level state OFF, Q=0. Therefore O1..O4=0, H1=0, O7=O8=O9=0, and RC=CE.
- Clr asserted mid-operation overrides every other input in that cycle. Start, Ld and CE are ignored during Clr.
- Init latency: Start high at edge N gives O1=1 after edge N. With I1..I4 all high, H1=1 after edge N+4.
- Level sequencer response: one cycle from the en/sensor change to the output change.
- H1 falling (via Clr) returns the level sequencer to OFF at the same edge.
- Counter load-to-RC latency: a load of value v followed by continuous CE gives RC=1 during the (v+1)th cycle after the load edge. A load of 0 gives RC=1 in the first cycle, provided CE=1.
- Ld and CE asserted together: the load wins and no decrement occurs that cycle.

## Test plan
- Clr pulse, then Start, then raise I1, I2, I3, I4 one every 2 cycles -> O1..O4 rise in order, each one cycle after its enabling input; H1=1 one cycle after I4; Clr then returns all outputs to 0.
- Start=0 with I1..I4=1 -> sequencer stays in IDLE; all outputs remain 0.
- H1=1, O6=1, raise I7, then I6, then I5 -> O9=1 from enable until one cycle after I5, then O8=1. Drop I5 -> O8 holds. Drop I6 -> O9=1.
- H1=1, O6=1, I5=1 with I6=0 -> O7=1. Restore I6=I7=1 -> OFF, then FULL with O8=1. O6=0 -> all outputs 0.
- Counter: Ld with I=4'b0011, then CE=1 -> Q goes 3,2,1,0 then 15; RC=1 only while Q=0 and CE=1.
- Counter: Ld=1 and CE=1 together with I=4'b1000 -> Q=8 with no decrement that cycle. CE=0 -> Q holds and RC=0.

Source files
------------

// File: rtl/init_operation_cont_ld.sv
// Control core for the agricultural automation chain: init sequencer, reservoir level
// sequencer and a 4-bit loadable down-counter sharing one clock and reset.
module init_operation_cont_ld (
  input  logic       Ck,
  input  logic       Clr,
  input  logic       Start,
  input  logic       I1,
  input  logic       I2,
  input  logic       I3,
  input  logic       I4,
  input  logic       I5,
  input  logic       I6,
  input  logic       I7,
  input  logic       O6,
  input  logic       CE,
  input  logic       Ld,
  input  logic [3:0] I,
  output logic       O1,
  output logic       O2,
  output logic       O3,
  output logic       O4,
  output logic       H1,
  output logic       O7,
  output logic       O8,
  output logic       O9,
  output logic [3:0] Q,
  output logic       RC
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [2:0] {
    INIT_IDLE,
    INIT_W1,
    INIT_W2,
    INIT_W3,
    INIT_W4,
    INIT_DONE
  } init_state_t;

  typedef enum logic [1:0] {
    LVL_OFF,
    LVL_FILL,
    LVL_FULL,
    LVL_FAULT
  } lvl_state_t;

  init_state_t        init_state;
  init_state_t        init_next;
  logic [STEP_W-1:0]  step_cmd_next;
  logic               ready_next;

  lvl_state_t         lvl_state;
  lvl_state_t         lvl_next;
  logic               lvl_en;
  logic               incons;
  logic               alarm_next;
  logic               full_next;
  logic               pump_next;

  logic [CNT_W-1:0]   cnt;

  // Init sequencer state register; actuator and ready flags registered from next state
  always_ff @(posedge Ck) begin
    if (Clr) begin
      init_state          <= INIT_IDLE;
      {O1, O2, O3, O4}    <= '0;
      H1                  <= 1'b0;
    end else begin
      init_state          <= init_next;
      {O1, O2, O3, O4}    <= step_cmd_next;
      H1                  <= ready_next;
    end
  end

  // Init next-state and cumulative actuator decode
  always_comb begin
    init_next     = init_state;
    step_cmd_next = '0;
    ready_next    = 1'b0;
    case (init_state)
      INIT_IDLE: if (Start) init_next = INIT_W1;
      INIT_W1:   if (I1)    init_next = INIT_W2;
      INIT_W2:   if (I2)    init_next = INIT_W3;
      INIT_W3:   if (I3)    init_next = INIT_W4;
      INIT_W4:   if (I4)    init_next = INIT_DONE;
      INIT_DONE:            init_next = INIT_DONE;
      default:              init_next = INIT_IDLE;
    endcase
    case (init_next)
      INIT_W1:   step_cmd_next = STEP_W'(4'b1000);
      INIT_W2:   step_cmd_next = STEP_W'(4'b1100);
      INIT_W3:   step_cmd_next = STEP_W'(4'b1110);
      INIT_W4:   step_cmd_next = STEP_W'(4'b1111);
      INIT_DONE: begin
        step_cmd_next = STEP_W'(4'b1111);
        ready_next    = 1'b1;
      end
      default:   step_cmd_next = '0;
    endcase
  end

  assign lvl_en = H1 & O6;
  // Sensors must nest: high implies mid, mid implies low
  assign incons = (I5 & ~I6) | (I6 & ~I7);

  // Level sequencer state register with registered Moore outputs
  always_ff @(posedge Ck) begin
    if (Clr) begin
      lvl_state <= LVL_OFF;
      O7        <= 1'b0;
      O8        <= 1'b0;
      O9        <= 1'b0;
    end else begin
      lvl_state <= lvl_next;
      O7        <= alarm_next;
      O8        <= full_next;
      O9        <= pump_next;
    end
  end

  // Level next-state: disable beats fault, fault beats regulation
  always_comb begin
    lvl_next   = lvl_state;
    alarm_next = 1'b0;
    full_next  = 1'b0;
    pump_next  = 1'b0;
    if (!lvl_en) begin
      lvl_next = LVL_OFF;
    end else if (incons) begin
      lvl_next = LVL_FAULT;
    end else begin
      case (lvl_state)
        LVL_OFF:   lvl_next = I5 ? LVL_FULL : LVL_FILL;
        LVL_FILL:  if (I5)  lvl_next = LVL_FULL;
        LVL_FULL:  if (!I6) lvl_next = LVL_FILL;
        LVL_FAULT: lvl_next = LVL_OFF;
        default:   lvl_next = LVL_OFF;
      endcase
    end
    case (lvl_next)
      LVL_FILL:  pump_next  = 1'b1;
      LVL_FULL:  full_next  = 1'b1;
      LVL_FAULT: alarm_next = 1'b1;
      default:   ;
    endcase
  end

  // Loadable down-counter: load wins over decrement
  always_ff @(posedge Ck) begin
    if (Clr) begin
      cnt <= '0;
    end else if (Ld) begin
      cnt <= I;
    end else if (CE) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign Q  = cnt;
  assign RC = CE & (cnt == '0);

endmodule

// File: tb/tb_init_operation_cont_ld.sv
// Directed bench for init_operation_cont_ld; expected output vectors queued per step.
module tb_init_operation_cont_ld;

  logic       Ck = 1'b0;
  logic       Clr, Start, I1, I2, I3, I4, I5, I6, I7, O6, CE, Ld;
  logic [3:0] I;
  logic       O1, O2, O3, O4, H1, O7, O8, O9, RC;
  logic [3:0] Q;

  int tests  = 0;
  int errors = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];

  init_operation_cont_ld dut (
    .Ck(Ck), .Clr(Clr), .Start(Start),
    .I1(I1), .I2(I2), .I3(I3), .I4(I4),
    .I5(I5), .I6(I6), .I7(I7), .O6(O6),
    .CE(CE), .Ld(Ld), .I(I),
    .O1(O1), .O2(O2), .O3(O3), .O4(O4), .H1(H1),
    .O7(O7), .O8(O8), .O9(O9), .Q(Q), .RC(RC)
  );

  always #5 Ck = ~Ck;

  // Packs {O1..O4, H1, O7, O8, O9, Q, RC}
  function automatic logic [12:0] ev(input logic [3:0] o, input logic h, input logic a7,
                                     input logic a8, input logic a9, input logic [3:0] q,
                                     input logic rc);
    return {o, h, a7, a8, a9, q, rc};
  endfunction

  task automatic step(input logic [12:0] e, input string tag);
    logic [12:0] obs;
    logic [12:0] want;
    string       t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge Ck);
    #1;
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    obs  = {O1, O2, O3, O4, H1, O7, O8, O9, Q, RC};
    tests++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", t, obs, want);
    end
  endtask

  initial begin
    Clr = 1'b1; Start = 1'b0; {I1, I2, I3, I4} = '0; {I5, I6, I7} = '0;
    O6 = 1'b0; CE = 1'b0; Ld = 1'b0; I = 4'd0;
    #1;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "reset");
    CE = 1'b1; Ld = 1'b1; I = 4'd7; Start = 1'b1;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 1), "reset_overrides");
    CE = 1'b0; Ld = 1'b0; Start = 1'b0; Clr = 1'b0;

    // Start low: sensors alone never move the sequencer
    {I1, I2, I3, I4} = 4'b1111;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "idle_hold0");
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "idle_hold1");
    {I1, I2, I3, I4} = 4'b0000;

    // Stepped confirmations, one every two cycles
    Start = 1'b1;
    step(ev(4'b1000, 0, 0, 0, 0, 4'd0, 0), "init_w1");
    Start = 1'b0;
    step(ev(4'b1000, 0, 0, 0, 0, 4'd0, 0), "init_w1_hold");
    I1 = 1'b1;
    step(ev(4'b1100, 0, 0, 0, 0, 4'd0, 0), "init_w2");
    step(ev(4'b1100, 0, 0, 0, 0, 4'd0, 0), "init_w2_hold");
    I2 = 1'b1;
    step(ev(4'b1110, 0, 0, 0, 0, 4'd0, 0), "init_w3");
    step(ev(4'b1110, 0, 0, 0, 0, 4'd0, 0), "init_w3_hold");
    I3 = 1'b1;
    step(ev(4'b1111, 0, 0, 0, 0, 4'd0, 0), "init_w4");
    step(ev(4'b1111, 0, 0, 0, 0, 4'd0, 0), "init_w4_hold");
    I4 = 1'b1;
    step(ev(4'b1111, 1, 0, 0, 0, 4'd0, 0), "init_done");
    Clr = 1'b1;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "init_clr");
    Clr = 1'b0;

    // Sensors already high: one state per cycle after Start
    Start = 1'b1;
    step(ev(4'b1000, 0, 0, 0, 0, 4'd0, 0), "fast_w1");
    Start = 1'b0;
    step(ev(4'b1100, 0, 0, 0, 0, 4'd0, 0), "fast_w2");
    step(ev(4'b1110, 0, 0, 0, 0, 4'd0, 0), "fast_w3");
    step(ev(4'b1111, 0, 0, 0, 0, 4'd0, 0), "fast_w4");
    step(ev(4'b1111, 1, 0, 0, 0, 4'd0, 0), "fast_done");

    // Filling the reservoir from empty
    O6 = 1'b1;
    step(ev(4'b1111, 1, 0, 0, 1, 4'd0, 0), "lvl_fill");
    I7 = 1'b1;
    step(ev(4'b1111, 1, 0, 0, 1, 4'd0, 0), "lvl_fill_low");
    I6 = 1'b1;
    step(ev(4'b1111, 1, 0, 0, 1, 4'd0, 0), "lvl_fill_mid");
    I5 = 1'b1;
    step(ev(4'b1111, 1, 0, 1, 0, 4'd0, 0), "lvl_full");
    I5 = 1'b0;
    step(ev(4'b1111, 1, 0, 1, 0, 4'd0, 0), "lvl_hysteresis");
    I6 = 1'b0;
    step(ev(4'b1111, 1, 0, 0, 1, 4'd0, 0), "lvl_refill");

    // Inconsistent sensors, recovery via OFF, then disable
    I5 = 1'b1;
    step(ev(4'b1111, 1, 1, 0, 0, 4'd0, 0), "lvl_fault");
    I6 = 1'b1;
    step(ev(4'b1111, 1, 0, 0, 0, 4'd0, 0), "lvl_fault_off");
    step(ev(4'b1111, 1, 0, 1, 0, 4'd0, 0), "lvl_fault_full");
    O6 = 1'b0;
    step(ev(4'b1111, 1, 0, 0, 0, 4'd0, 0), "lvl_disable");
    O6 = 1'b1;
    step(ev(4'b1111, 1, 0, 1, 0, 4'd0, 0), "lvl_reenable");
    Clr = 1'b1;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "lvl_clr_mid");
    Clr = 1'b0;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "lvl_after_clr");

    // Counter: load 3 then count through zero
    Ld = 1'b1; I = 4'b0011;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd3, 0), "cnt_load3");
    Ld = 1'b0; CE = 1'b1;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd2, 0), "cnt_2");
    step(ev(4'b0000, 0, 0, 0, 0, 4'd1, 0), "cnt_1");
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 1), "cnt_0_rc");
    step(ev(4'b0000, 0, 0, 0, 0, 4'd15, 0), "cnt_wrap");

    // Load and enable together: load wins
    Ld = 1'b1; I = 4'b1000;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd8, 0), "cnt_ld_ce");
    Ld = 1'b0; CE = 1'b0;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd8, 0), "cnt_hold");

    // Load of zero with enable: terminal count in first cycle
    Ld = 1'b1; CE = 1'b1; I = 4'd0;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 1), "cnt_load0_rc");
    CE = 1'b0;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 0), "cnt_zero_no_ce");
    Ld = 1'b0; CE = 1'b1;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd15, 0), "cnt_wrap2");
    Clr = 1'b1; Ld = 1'b1; I = 4'd5;
    step(ev(4'b0000, 0, 0, 0, 0, 4'd0, 1), "cnt_clr_wins");
    Clr = 1'b0; Ld = 1'b0; CE = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
